// File: rtl/botao_irq_servicer_pkg.sv
// Shared definitions for the button interrupt servicer: FSM encoding, PIO
// register map and the bus pattern each state drives.
package botao_irq_servicer_pkg;

   typedef enum logic [3:0] {
      INIT_MASK,
      IDLE,
      RD_CAP,
      WAIT_CAP,
      CLR_CAP,
      RD_DATA,
      WAIT_DATA,
      EMIT,
      HOLD,
      CLR_HOLD
   } state_t;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd2;
   localparam logic [1:0] REG_CAPTURE = 2'd3;

   typedef struct packed {
      logic        chipselect;
      logic        write_n;
      logic [1:0]  address;
      logic [31:0] writedata;
   } pio_bus_t;

   localparam pio_bus_t BUS_IDLE = '{chipselect: 1'b0, write_n: 1'b1,
                                     address: REG_DATA, writedata: 32'd0};

   function automatic pio_bus_t bus_for(state_t s);
      pio_bus_t b;
      b = BUS_IDLE;
      case (s)
         INIT_MASK: b = '{chipselect: 1'b1, write_n: 1'b0, address: REG_MASK,    writedata: 32'd1};
         RD_CAP:    b = '{chipselect: 1'b1, write_n: 1'b1, address: REG_CAPTURE, writedata: 32'd0};
         CLR_CAP:   b = '{chipselect: 1'b1, write_n: 1'b0, address: REG_CAPTURE, writedata: 32'd0};
         RD_DATA:   b = '{chipselect: 1'b1, write_n: 1'b1, address: REG_DATA,    writedata: 32'd0};
         CLR_HOLD:  b = '{chipselect: 1'b1, write_n: 1'b0, address: REG_CAPTURE, writedata: 32'd0};
         default:   b = BUS_IDLE;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/botao_irq_servicer_if.sv
// Avalon-style link between the servicer (master) and the button PIO (slave).
interface botao_irq_servicer_if;

   logic        irq;
   logic [31:0] readdata;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;

   modport master (
      input  irq, readdata,
      output address, chipselect, write_n, writedata
   );

   modport slave (
      output irq, readdata,
      input  address, chipselect, write_n, writedata
   );

endinterface

// File: rtl/botao_irq_servicer.sv
// Services button PIO interrupts: reads and clears edge capture, samples the
// pin, emits one event per press and discards bounce edges after a hold-off.
module botao_irq_servicer
   import botao_irq_servicer_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int HOLD_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset_n,
   botao_irq_servicer_if.master pio,
   input  logic                 clr_count,
   output logic                 event_valid,
   output logic                 event_level,
   output logic [CNT_W-1:0]     press_count,
   output logic                 busy
);

   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   pio_bus_t         bus_q, bus_d;
   logic             event_valid_q, event_valid_d;
   logic             event_level_q, event_level_d;
   logic [CNT_W-1:0] press_count_q, press_count_d;
   logic             busy_q, busy_d;
   logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d       = state_q;
      hold_cnt_d    = '0;
      event_level_d = event_level_q;
      press_count_d = press_count_q;

      case (state_q)
         // The mask write is issued on the bus one cycle after reset release;
         // leave only once it has actually been driven.
         INIT_MASK: if (bus_q.chipselect) state_d = IDLE;
         IDLE:      if (pio.irq) state_d = RD_CAP;
         RD_CAP:    state_d = WAIT_CAP;
         WAIT_CAP:  state_d = pio.readdata[0] ? CLR_CAP : IDLE;
         CLR_CAP:   state_d = RD_DATA;
         RD_DATA:   state_d = WAIT_DATA;
         WAIT_DATA: begin
            event_level_d = pio.readdata[0];
            state_d       = EMIT;
         end
         EMIT: begin
            press_count_d = press_count_q + CNT_W'(1);
            state_d       = (HOLD_CYCLES == 0) ? CLR_HOLD : HOLD;
         end
         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) state_d = CLR_HOLD;
            else                         hold_cnt_d = hold_cnt_q + HC_W'(1);
         end
         CLR_HOLD:  state_d = IDLE;
         default:   state_d = INIT_MASK;
      endcase

      if (clr_count) press_count_d = '0;

      // Outputs are decoded from the next state so the registered bus lines up
      // with the state that owns it.
      bus_d         = bus_for(state_d);
      event_valid_d = (state_d == EMIT);
      busy_d        = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= INIT_MASK;
         bus_q         <= BUS_IDLE;
         event_valid_q <= 1'b0;
         event_level_q <= 1'b0;
         press_count_q <= '0;
         busy_q        <= 1'b1;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         bus_q         <= bus_d;
         event_valid_q <= event_valid_d;
         event_level_q <= event_level_d;
         press_count_q <= press_count_d;
         busy_q        <= busy_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign pio.chipselect = bus_q.chipselect;
   assign pio.write_n    = bus_q.write_n;
   assign pio.address    = bus_q.address;
   assign pio.writedata  = bus_q.writedata;

   assign event_valid = event_valid_q;
   assign event_level = event_level_q;
   assign press_count = press_count_q;
   assign busy        = busy_q;

   logic unused_readdata;
   assign unused_readdata = ^pio.readdata[31:1];

endmodule

// File: doc/botao_irq_servicer.md
BOTAO_IRQ_SERVICER -- requirements
Module: botao_irq_servicer

Interface
REQ-001 Parameter CNT_W, default 16, width of press counter.
REQ-002 Parameter HOLD_CYCLES, default 1000, debounce hold-off length in clk cycles; 0 allowed.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 irq  in  1  interrupt from button PIO slave, level.
REQ-006 readdata  in  32  PIO read data, valid the cycle after a read is issued.
REQ-007 address  out  2  PIO register select: 0 data, 2 irq mask, 3 edge capture.
REQ-008 chipselect  out  1  PIO access strobe.
REQ-009 write_n  out  1  PIO write strobe, active-low.
REQ-010 writedata  out  32  PIO write data.
REQ-011 clr_count  in  1  synchronous pulse, clears press_count.
REQ-012 event_valid  out  1  one-cycle pulse per serviced press.
REQ-013 event_level  out  1  pin level read back during service, valid with event_valid.
REQ-014 press_count  out  CNT_W  number of serviced presses, wraps.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be INIT_MASK, IDLE, RD_CAP, WAIT_CAP, CLR_CAP, RD_DATA, WAIT_DATA, EMIT, HOLD, CLR_HOLD.
REQ-017 All bus outputs SHALL be registered; in a non-access state: chipselect 0, write_n 1, address 0, writedata 0.
REQ-018 INIT_MASK: one write cycle, address 2, writedata 1; next IDLE.
REQ-019 IDLE: bus idle; irq 1 -> RD_CAP, else stay.
REQ-020 RD_CAP: one read cycle (chipselect 1, write_n 1, address 3); next WAIT_CAP.
REQ-021 WAIT_CAP: bus idle; sample readdata[0]; 1 -> CLR_CAP, 0 -> IDLE (spurious, no event).
REQ-022 CLR_CAP: one write cycle, address 3, writedata 0; next RD_DATA.
REQ-023 RD_DATA: one read cycle, address 0; next WAIT_DATA.
REQ-024 WAIT_DATA: bus idle; register readdata[0] into event_level; next EMIT.
REQ-025 EMIT: event_valid 1 for exactly this cycle; press_count +1 modulo 2^CNT_W; next HOLD, or CLR_HOLD if HOLD_CYCLES = 0.
REQ-026 HOLD: bus idle, irq ignored; counter runs HOLD_CYCLES cycles, then CLR_HOLD.
REQ-027 CLR_HOLD: one write cycle, address 3, writedata 0 (discard bounce edges); next IDLE.
REQ-028 Latency irq rise (sampled in IDLE) to event_valid SHALL be 6 cycles.
REQ-029 clr_count coincident with EMIT increment: clear wins, press_count = 0.
REQ-030 Edge arriving during CLR_CAP..CLR_HOLD SHALL be discarded; edge after CLR_HOLD serviced normally.
REQ-031 irq held high continuously SHALL re-service once per full pass (no lock-up).

Reset
REQ-032 On reset_n low: state INIT_MASK, chipselect 0, write_n 1, address 0, writedata 0, event_valid 0, event_level 0, press_count 0, busy 1, hold counter 0.
REQ-033 Reset mid-access SHALL abort immediately; after release, sequence restarts at INIT_MASK.

Structure
REQ-034 Shared package SHALL hold state encoding and PIO register address constants (DATA=0, MASK=2, CAPTURE=3).
REQ-035 Single flat module; hold-off counter SHALL be inline, no sub-module.

Verification
REQ-036 Release reset -> first cycle: chipselect 1, write_n 0, address 2, writedata 1; then idle bus, busy 0.
REQ-037 Press with PIO model (pin 1, capture 1, irq 1) -> read 3, write 3, read 0, event_valid 6 cycles after irq, event_level 1, press_count 1.
REQ-038 irq with capture read 0 -> return to IDLE, no event_valid, press_count unchanged.
REQ-039 HOLD_CYCLES=4, bounce edges during HOLD -> single event; CLR_HOLD write after 4 hold cycles; count +1 only.
REQ-040 press_count = 2^CNT_W-1 plus one press -> 0; clr_count coincident with EMIT -> 0.
REQ-041 reset_n low during RD_DATA -> outputs at reset values same cycle; INIT_MASK write follows release.
